// File: rtl/foveated_block_expander_if.sv
// rtl/foveated_block_expander_if.sv - sample-in / beat-out stream bundle for foveated_block_expander
// master: the expander (consumes samples, produces beats); slave: its environment.
interface foveated_block_expander_if #(
  parameter int DATA_W = 24,
  parameter int BLK    = 12,
  parameter int CNT_W  = 11
);
  logic [DATA_W-1:0] i_s_data;
  logic              i_s_valid;
  logic              o_s_ready;

  logic [DATA_W-1:0] o_data;
  logic [BLK-1:0]    o_mask;
  logic [CNT_W-1:0]  o_row;
  logic [2:0]        o_rep;
  logic [CNT_W-1:0]  o_blk_x;
  logic [CNT_W-1:0]  o_blk_y;
  logic              o_valid;
  logic              i_ready;
  logic              o_sof;
  logic              o_eof;

  modport master (
    input  i_s_data, i_s_valid, i_ready,
    output o_s_ready, o_data, o_mask, o_row, o_rep, o_blk_x, o_blk_y,
           o_valid, o_sof, o_eof
  );

  modport slave (
    output i_s_data, i_s_valid, i_ready,
    input  o_s_ready, o_data, o_mask, o_row, o_rep, o_blk_x, o_blk_y,
           o_valid, o_sof, o_eof
  );
endinterface

// File: rtl/foveated_block_expander.sv
// rtl/foveated_block_expander.sv - tile walker emitting gaze-dependent subsampled beats from a FWFT FIFO
// Optional FOV_FLUSH_EN: i_sof outside IDLE flushes the FIFO and restarts the frame.
module foveated_block_expander #(
  parameter int DATA_W  = 24,
  parameter int IMG_W   = 1920,
  parameter int IMG_H   = 1080,
  parameter int BLK     = 12,
  parameter int FIFO_AW = 11,
  parameter int CNT_W   = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  foveated_block_expander_if.master bus,
  input  logic                 i_sof,
  input  logic [CNT_W-1:0]     i_gaze_x,
  input  logic [CNT_W-1:0]     i_gaze_y,
  input  logic [2*CNT_W+2:0]   i_thres_1,
  input  logic [2*CNT_W+2:0]   i_thres_2,
  input  logic [2*CNT_W+2:0]   i_thres_3,
  output logic                 o_param_ready,
  output logic                 o_sof_err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = 2*CNT_W + 3;
  localparam int SW    = 2*CNT_W + 2;
  localparam int NW    = FIFO_AW + 1;
  localparam logic [CNT_W:0] HALF_E  = (CNT_W+1)'(BLK/2);
  localparam logic [CNT_W:0] BLK_E   = (CNT_W+1)'(BLK);
  localparam logic [CNT_W:0] IMG_W_E = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0] IMG_H_E = (CNT_W+1)'(IMG_H);

  typedef enum logic [2:0] {S_IDLE, S_DIST, S_CHECK, S_EMIT, S_EOF} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [NW-1:0]         count, count_nxt, need;
  logic                  s_ready_q, flush, push, pop, start;

  logic [CNT_W-1:0]      gx_q, gy_q, blk_x, blk_y, span, span_new, sr, sc, span_m1, f_ext;
  logic [TW-1:0]         t1_q, t2_q, t3_q, d2;
  logic [1:0]            dist_cnt;
  logic signed [CNT_W:0] dx, dy;
  logic [SW-1:0]         dxe, dye, sq_x, sq_y;
  logic [2:0]            f_q, f_new;
  logic [CNT_W:0]        nx, ny;
  logic                  valid_q, sof_q, eof_q, param_ready_q, sof_err_q;
  logic [BLK-1:0]        mask_base;

`ifdef FOV_FLUSH_EN
  assign flush = i_sof && (state != S_IDLE);
`else
  assign flush = 1'b0;
`endif

  assign start = (i_sof && (state == S_IDLE)) || flush;
  assign push  = bus.i_s_valid && s_ready_q && !flush;
  assign pop   = valid_q && bus.i_ready && !flush;

  always_comb begin
    count_nxt = count;
    if (flush)              count_nxt = '0;
    else if (push && !pop)  count_nxt = count + NW'(1);
    else if (pop && !push)  count_nxt = count - NW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      count     <= count_nxt;
      s_ready_q <= (count_nxt != NW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_s_data;
  end

  // Sign-extend before squaring so the unsigned product equals dx*dx.
  assign dxe = {{(CNT_W+1){dx[CNT_W]}}, dx};
  assign dye = {{(CNT_W+1){dy[CNT_W]}}, dy};
  assign d2  = {1'b0, sq_x} + {1'b0, sq_y};

  always_comb begin
    f_new = 3'd1;
    if (d2 > t1_q)      f_new = 3'd4;
    else if (d2 > t2_q) f_new = 3'd3;
    else if (d2 > t3_q) f_new = 3'd2;
    case (f_new)
      3'd4:    span_new = CNT_W'(BLK/4);
      3'd3:    span_new = CNT_W'(BLK/3);
      3'd2:    span_new = CNT_W'(BLK/2);
      default: span_new = CNT_W'(BLK);
    endcase
  end

  assign need    = NW'(span) * NW'(span);
  assign span_m1 = span - CNT_W'(1);
  assign f_ext   = CNT_W'(f_q);
  assign nx      = {1'b0, blk_x} + BLK_E;
  assign ny      = {1'b0, blk_y} + BLK_E;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      gx_q          <= '0;
      gy_q          <= '0;
      t1_q          <= '0;
      t2_q          <= '0;
      t3_q          <= '0;
      blk_x         <= '0;
      blk_y         <= '0;
      dist_cnt      <= '0;
      dx            <= '0;
      dy            <= '0;
      sq_x          <= '0;
      sq_y          <= '0;
      f_q           <= '0;
      span          <= '0;
      sr            <= '0;
      sc            <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      param_ready_q <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      if (i_sof && (state != S_IDLE)) sof_err_q <= 1'b1;
      if (start) begin
        gx_q          <= i_gaze_x;
        gy_q          <= i_gaze_y;
        t1_q          <= i_thres_1;
        t2_q          <= i_thres_2;
        t3_q          <= i_thres_3;
        blk_x         <= '0;
        blk_y         <= '0;
        dist_cnt      <= '0;
        sr            <= '0;
        sc            <= '0;
        valid_q       <= 1'b0;
        sof_q         <= 1'b0;
        eof_q         <= 1'b0;
        param_ready_q <= 1'b0;
        state         <= S_DIST;
      end else begin
        case (state)
          S_IDLE: param_ready_q <= 1'b1;
          S_DIST: begin
            dist_cnt <= dist_cnt + 2'd1;
            case (dist_cnt)
              2'd0: begin
                dx <= {1'b0, gx_q} - ({1'b0, blk_x} + HALF_E);
                dy <= {1'b0, gy_q} - ({1'b0, blk_y} + HALF_E);
              end
              2'd1: begin
                sq_x <= dxe * dxe;
                sq_y <= dye * dye;
              end
              default: begin
                f_q      <= f_new;
                span     <= span_new;
                dist_cnt <= '0;
                state    <= S_CHECK;
              end
            endcase
          end
          S_CHECK: begin
            if (count >= need) begin
              valid_q <= 1'b1;
              sr      <= '0;
              sc      <= '0;
              sof_q   <= (blk_x == '0) && (blk_y == '0);
              state   <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (bus.i_ready) begin
              sof_q <= 1'b0;
              if (sc == span_m1) begin
                sc <= '0;
                if (sr == span_m1) begin
                  sr      <= '0;
                  valid_q <= 1'b0;
                  if (nx < IMG_W_E) begin
                    blk_x <= nx[CNT_W-1:0];
                    state <= S_DIST;
                  end else if (ny < IMG_H_E) begin
                    blk_x <= '0;
                    blk_y <= ny[CNT_W-1:0];
                    state <= S_DIST;
                  end else begin
                    eof_q <= 1'b1;
                    state <= S_EOF;
                  end
                end else begin
                  sr <= sr + CNT_W'(1);
                end
              end else begin
                sc <= sc + CNT_W'(1);
              end
            end
          end
          S_EOF: begin
            eof_q         <= 1'b0;
            param_ready_q <= 1'b1;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (f_q)
      3'd1:    mask_base = BLK'(1);
      3'd2:    mask_base = BLK'(3);
      3'd3:    mask_base = BLK'(7);
      3'd4:    mask_base = BLK'(15);
      default: mask_base = '0;
    endcase
  end

  // Beat fields are forced to zero whenever no beat is offered.
  assign bus.o_valid   = valid_q;
  assign bus.o_data    = valid_q ? mem[rd_ptr] : '0;
  assign bus.o_mask    = valid_q ? (mask_base << (sc * f_ext)) : '0;
  assign bus.o_row     = valid_q ? (sr * f_ext) : '0;
  assign bus.o_rep     = valid_q ? f_q : 3'd0;
  assign bus.o_blk_x   = blk_x;
  assign bus.o_blk_y   = blk_y;
  assign bus.o_sof     = sof_q;
  assign bus.o_eof     = eof_q;
  assign bus.o_s_ready = s_ready_q;
  assign o_param_ready = param_ready_q;
  assign o_sof_err     = sof_err_q;
endmodule

// File: tb/tb_foveated_block_expander.sv
// tb/tb_foveated_block_expander.sv - scoreboard bench for foveated_block_expander on a 24x12 frame
module tb_foveated_block_expander;
  localparam int DW  = 24;
  localparam int IW  = 24;
  localparam int IH  = 12;
  localparam int BLK = 12;
  localparam int FAW = 9;
  localparam int CW  = 5;
  localparam int TW  = 2*CW + 3;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic [CW-1:0] gaze_x = '0, gaze_y = '0;
  logic [TW-1:0] thres_1 = '0, thres_2 = '0, thres_3 = '0;
  logic          param_ready, sof_err;

  always #5 clk = ~clk;

  foveated_block_expander_if #(.DATA_W(DW), .BLK(BLK), .CNT_W(CW)) bus ();

  foveated_block_expander #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .BLK(BLK), .FIFO_AW(FAW), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_sof(sof),
    .i_gaze_x(gaze_x), .i_gaze_y(gaze_y),
    .i_thres_1(thres_1), .i_thres_2(thres_2), .i_thres_3(thres_3),
    .o_param_ready(param_ready), .o_sof_err(sof_err)
  );

  int          n_checks = 0, n_fail = 0;
  int          push_idx = 0, pop_idx = 0;
  int          cyc = 0, last_acc = -10, acc_cnt = 0, eof_cnt = 0;
  bit          mon_en = 0, seen_valid = 0, toggle_en = 0, prev_eof = 0;
  logic [63:0] exp_q[$];
  logic [63:0] dummy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sample_val(input int k);
    logic [31:0] v;
    v = k * 32'h009E3779 + 32'h0005A5A5;
    return v[DW-1:0];
  endfunction

  function automatic logic [63:0] pack_beat(input logic [DW-1:0] d, input logic [BLK-1:0] m,
                                            input logic [CW-1:0] r, input logic [2:0] rep,
                                            input logic [CW-1:0] bx, input logic [CW-1:0] by,
                                            input logic s);
    return {9'd0, d, m, r, rep, bx, by, s};
  endfunction

  function automatic int level(input int gx, input int gy, input int bx, input int by,
                               input int t1, input int t2, input int t3);
    int dx, dy, d2;
    dx = gx - (bx + BLK/2);
    dy = gy - (by + BLK/2);
    d2 = dx*dx + dy*dy;
    if (d2 > t1) return 4;
    if (d2 > t2) return 3;
    if (d2 > t3) return 2;
    return 1;
  endfunction

  task automatic queue_frame(input int gx, input int gy, input int t1, input int t2, input int t3);
    int f, n;
    logic [BLK-1:0] m;
    for (int by = 0; by < IH; by += BLK)
      for (int bx = 0; bx < IW; bx += BLK) begin
        f = level(gx, gy, bx, by, t1, t2, t3);
        n = BLK / f;
        for (int sr = 0; sr < n; sr++)
          for (int sc = 0; sc < n; sc++) begin
            m = BLK'((1 << f) - 1) << (sc * f);
            exp_q.push_back(pack_beat(sample_val(pop_idx), m, CW'(sr*f), 3'(f), CW'(bx), CW'(by),
                                      (bx == 0 && by == 0 && sr == 0 && sc == 0)));
            pop_idx++;
          end
      end
  endtask

  task automatic start_frame(input int gx, input int gy, input int t1, input int t2, input int t3);
    check_eq("param_ready_idle", param_ready, 1);
    gaze_x = CW'(gx); gaze_y = CW'(gy);
    thres_1 = TW'(t1); thres_2 = TW'(t2); thres_3 = TW'(t3);
    queue_frame(gx, gy, t1, t2, t3);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic push_n(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      bus.i_s_data  = sample_val(push_idx);
      bus.i_s_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.o_s_ready && w < 1000) begin @(negedge clk); w++; end
      if (w == 1000) begin
        check_eq("push_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      push_idx++;
    end
    bus.i_s_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_eof(input int target, input int budget);
    int k;
    k = 0;
    while (eof_cnt < target && k < budget) begin @(posedge clk); k++; end
    #1;
    check_eq("frame_done", eof_cnt >= target, 1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (acc_cnt < target && k < budget) begin @(posedge clk); k++; end
    #1;
    check_eq("beats_reached", acc_cnt >= target, 1);
  endtask

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_en) bus.i_ready = ~bus.i_ready;
      else           bus.i_ready = 1'b1;
    end
  end

  // Peek the scoreboard head on every offered beat so stalled beats are checked for stability.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      if (bus.o_valid) begin
        seen_valid = 1;
        if (exp_q.size() == 0) check_eq("unexpected_beat", 1, 0);
        else begin
          check_eq("beat", pack_beat(bus.o_data, bus.o_mask, bus.o_row, bus.o_rep,
                                     bus.o_blk_x, bus.o_blk_y, bus.o_sof), exp_q[0]);
          if (bus.i_ready) begin
            dummy = exp_q.pop_front();
            acc_cnt++;
            last_acc = cyc;
          end
        end
      end
      if (bus.o_eof) begin
        check_eq("eof_gap", 64'(cyc - last_acc), 1);
        check_eq("eof_drain", exp_q.size(), 0);
        check_eq("eof_pulse", prev_eof, 0);
        eof_cnt++;
      end
      prev_eof = bus.o_eof;
    end
  end

  initial begin
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", bus.o_valid, 0);
    check_eq("rst_s_ready", bus.o_s_ready, 0);
    check_eq("rst_param_ready", param_ready, 0);
    check_eq("rst_eof", bus.o_eof, 0);
    check_eq("rst_sof_err", sof_err, 0);
    check_eq("rst_mask", bus.o_mask, 0);
    check_eq("rst_data", bus.o_data, 0);
    rst_n = 1'b1;
    wait_cycles(2);
    check_eq("idle_s_ready", bus.o_s_ready, 1);
    mon_en = 1;

    // full-resolution frame, one-hot masks
    acc_cnt = 0;
    push_n(288);
    start_frame(0, 0, TMAX, TMAX, TMAX);
    wait_eof(1, 3000);
    check_eq("t1_beats", acc_cnt, 288);

    // coarsest level everywhere
    acc_cnt = 0;
    push_n(18);
    start_frame(31, 31, 0, 0, 0);
    wait_eof(2, 500);
    check_eq("t2_beats", acc_cnt, 18);

    // d2 == thres_3 on tile 0 stays at f=1
    acc_cnt = 0;
    push_n(180);
    start_frame(0, 0, TMAX, TMAX, 72);
    wait_eof(3, 3000);
    check_eq("t3_beats", acc_cnt, 180);

    // d2 == thres_3+1: f=2, held in CHECK until 36 samples, ready toggling
    acc_cnt = 0;
    push_n(35);
    seen_valid = 0;
    start_frame(0, 0, TMAX, TMAX, 71);
    wait_cycles(30);
    check_eq("check_hold", seen_valid, 0);
    push_n(1);
    toggle_en = 1;
    push_n(36);
    wait_eof(4, 2000);
    toggle_en = 0;
    check_eq("t4_beats", acc_cnt, 72);

    // FIFO full: no acceptance, no overwrite
    push_n(512);
    check_eq("fifo_full", bus.o_s_ready, 0);
    bus.i_s_data  = 24'hBADBAD;
    bus.i_s_valid = 1'b1;
    wait_cycles(3);
    check_eq("fifo_full_hold", bus.o_s_ready, 0);
    bus.i_s_valid = 1'b0;
    acc_cnt = 0;
    start_frame(0, 0, TMAX, TMAX, TMAX);
    wait_eof(5, 3000);
    check_eq("t5_beats", acc_cnt, 288);

    // i_sof mid-frame
    acc_cnt = 0;
    push_n(64);
    start_frame(0, 0, TMAX, TMAX, TMAX);
    wait_acc(50, 1000);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    check_eq("sof_err", sof_err, 1);
`ifdef FOV_FLUSH_EN
    exp_q.delete();
    pop_idx = push_idx;
    queue_frame(0, 0, TMAX, TMAX, TMAX);
    seen_valid = 0;
    wait_cycles(20);
    check_eq("flush_empty", seen_valid, 0);
    push_n(288);
    wait_eof(6, 3000);
`else
    wait_eof(6, 3000);
    check_eq("t6_beats", acc_cnt, 288);
`endif

    // asynchronous reset in the second tile's EMIT
    acc_cnt = 0;
    push_n(288);
    start_frame(0, 0, TMAX, TMAX, TMAX);
    wait_acc(150, 2000);
    check_eq("pre_rst_blk_x", bus.o_blk_x, 12);
    mon_en = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", bus.o_valid, 0);
    check_eq("arst_data", bus.o_data, 0);
    check_eq("arst_mask", bus.o_mask, 0);
    check_eq("arst_row", bus.o_row, 0);
    check_eq("arst_blk_x", bus.o_blk_x, 0);
    check_eq("arst_sof_err", sof_err, 0);
    check_eq("arst_s_ready", bus.o_s_ready, 0);
    check_eq("arst_param_ready", param_ready, 0);
    exp_q.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
